// File: rtl/sfi_pkg.sv
// rtl/sfi_pkg.sv - shared constants, state type and opcode helper for the SFI guard sequencer
// Purpose : opcode field position, the guarded (memory-access) opcode set,
//           the sequencer state encoding and a guarded-opcode predicate.
// Ports   : none (package).
package sfi_pkg;

    localparam int OPC_LSB = 26;
    localparam int OPC_W   = 6;

    localparam logic [OPC_W-1:0] OPC_GRD_40 = 6'd40;
    localparam logic [OPC_W-1:0] OPC_GRD_41 = 6'd41;
    localparam logic [OPC_W-1:0] OPC_GRD_42 = 6'd42;
    localparam logic [OPC_W-1:0] OPC_GRD_43 = 6'd43;
    localparam logic [OPC_W-1:0] OPC_GRD_44 = 6'd44;
    localparam logic [OPC_W-1:0] OPC_GRD_45 = 6'd45;
    localparam logic [OPC_W-1:0] OPC_GRD_46 = 6'd46;
    localparam logic [OPC_W-1:0] OPC_GRD_56 = 6'd56;
    localparam logic [OPC_W-1:0] OPC_GRD_60 = 6'd60;
    localparam logic [OPC_W-1:0] OPC_GRD_63 = 6'd63;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        TRAP  = 2'd3
    } state_t;

    function automatic logic opc_is_guarded(input logic [OPC_W-1:0] opc);
        return opc inside {OPC_GRD_40, OPC_GRD_41, OPC_GRD_42, OPC_GRD_43, OPC_GRD_44,
                           OPC_GRD_45, OPC_GRD_46, OPC_GRD_56, OPC_GRD_60, OPC_GRD_63};
    endfunction

endpackage

// File: rtl/sfi_guard_sequencer_if.sv
// rtl/sfi_guard_sequencer_if.sv - instruction-word stream bundle for the SFI guard sequencer
// Purpose : groups the input and output valid/ready word streams.
// Ports   : in_valid/in_ready/in_data   upstream word stream
//           out_valid/out_ready/out_data/out_guard  downstream word stream
// Modports: master = stream source/sink (fetch side + execute side)
//           slave  = the sequencer
interface sfi_guard_sequencer_if #(
    parameter int DATA_W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_guard;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_guard
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_guard
    );
endinterface

// File: rtl/sfi_opcode_decode.sv
// rtl/sfi_opcode_decode.sv - combinational guarded-opcode classifier
// Purpose : flags words whose opcode field selects a memory access.
// Ports   : in_data    in  DATA_W  instruction word
//           is_guarded out 1       opcode is in the guarded set
module sfi_opcode_decode
    import sfi_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0] in_data,
    output logic              is_guarded
);
    // Only the opcode field matters; the rest of the word is deliberately ignored.
    logic [DATA_W-1:0] unused_in_data;
    assign unused_in_data = in_data;

    assign is_guarded = opc_is_guarded(in_data[OPC_LSB +: OPC_W]);
endmodule

// File: rtl/sfi_guard_sequencer.sv
// rtl/sfi_guard_sequencer.sv - SFI address-guard sequencer between decode and execute
// Purpose : start/stop FSM, sandbox tag register, one-stage guarded output
//           register and saturating emit statistics.
// Ports   : clk, rst_n (async, active low)
//           start/stop pulses, busy status
//           cfg_we/cfg_tag_in tag write (IDLE only), cfg_err reject pulse
//           bus (slave) in/out word streams, out_guard marks rewritten words
//           guard_cnt/total_cnt saturating emit counters
//           trap/trap_clr tag-mismatch trap (only with SFI_TRAP_EN)
// Config  : `define SFI_TRAP_EN enables the tag-mismatch trap; otherwise
//           trap is 0 and trap_clr is ignored.
module sfi_guard_sequencer
    import sfi_pkg::*;
#(
    parameter int              DATA_W    = 64,
    parameter int              TAG_W     = 8,
    parameter int              CNT_W     = 32,
    parameter logic [TAG_W-1:0] RESET_TAG = 8'hA2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    output logic                 busy,
    input  logic                 cfg_we,
    input  logic [TAG_W-1:0]     cfg_tag_in,
    output logic                 cfg_err,
    output logic [CNT_W-1:0]     guard_cnt,
    output logic [CNT_W-1:0]     total_cnt,
    output logic                 trap,
    input  logic                 trap_clr,
    sfi_guard_sequencer_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_guard_q, out_guard_d;
    logic [CNT_W-1:0]  guard_cnt_q, guard_cnt_d;
    logic [CNT_W-1:0]  total_cnt_q, total_cnt_d;
    logic              cfg_err_q, cfg_err_d;
    logic              trap_q, trap_d;

    logic is_guarded;
    logic in_ready;
    logic in_hs;
    logic out_hs;
    logic trap_hit;

    sfi_opcode_decode #(.DATA_W(DATA_W)) u_decode (
        .in_data    (bus.in_data),
        .is_guarded (is_guarded)
    );

`ifndef SFI_TRAP_EN
    logic unused_trap_clr;
    assign unused_trap_clr = trap_clr;
`endif

    always_comb begin
        state_d     = state_q;
        tag_d       = tag_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_guard_d = out_guard_q;
        guard_cnt_d = guard_cnt_q;
        total_cnt_d = total_cnt_q;
        trap_d      = trap_q;
        in_ready    = 1'b0;
        // A rejected write is reported one cycle later, regardless of the state it lands in next.
        cfg_err_d   = cfg_we && (state_q != IDLE);
        out_hs      = out_valid_q && bus.out_ready;

        unique case (state_q)
            IDLE: begin
                if (cfg_we) tag_d = cfg_tag_in;
                if (start)  state_d = RUN;
            end
            RUN: begin
                in_ready = !out_valid_q || bus.out_ready;
                if (stop) state_d = DRAIN;
            end
            DRAIN: begin
                if (!out_valid_q || out_hs) state_d = IDLE;
            end
            TRAP: begin
`ifdef SFI_TRAP_EN
                // stop is ignored here; only trap_clr leaves TRAP.
                if (trap_clr) begin
                    state_d = IDLE;
                    trap_d  = 1'b0;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase

        in_hs = bus.in_valid && in_ready;

`ifdef SFI_TRAP_EN
        trap_hit = in_hs && is_guarded && (bus.in_data[DATA_W-1 -: TAG_W] != tag_q);
`else
        trap_hit = 1'b0;
`endif

        if (out_hs) begin
            out_valid_d = 1'b0;
            if (total_cnt_q != CNT_MAX) total_cnt_d = total_cnt_q + CNT_ONE;
            if (out_guard_q && (guard_cnt_q != CNT_MAX)) guard_cnt_d = guard_cnt_q + CNT_ONE;
        end

        if (trap_hit) begin
            // Offending word is consumed but never reaches the output register.
            state_d = TRAP;
            trap_d  = 1'b1;
        end else if (in_hs) begin
            out_valid_d = 1'b1;
            out_guard_d = is_guarded;
            out_data_d  = is_guarded ? {tag_q, bus.in_data[DATA_W-TAG_W-1:0]} : bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tag_q       <= RESET_TAG;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_guard_q <= 1'b0;
            guard_cnt_q <= '0;
            total_cnt_q <= '0;
            cfg_err_q   <= 1'b0;
            trap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tag_q       <= tag_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_guard_q <= out_guard_d;
            guard_cnt_q <= guard_cnt_d;
            total_cnt_q <= total_cnt_d;
            cfg_err_q   <= cfg_err_d;
            trap_q      <= trap_d;
        end
    end

    assign busy          = (state_q != IDLE);
    assign cfg_err       = cfg_err_q;
    assign guard_cnt     = guard_cnt_q;
    assign total_cnt     = total_cnt_q;
    assign trap          = trap_q;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_guard = out_guard_q;
endmodule
